// File: rtl/goofy_run_ctrl.sv
// goofy_run_ctrl: run controller for one or more GoofyCore instances.
// Sequences core reset, gates per-core clock enables (freezing each core once
// it halts), supports free-run and single-step execution, counts enabled
// cycles and enforces an optional watchdog limit.
module goofy_run_ctrl #(
  parameter int N_CORES      = 1,
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int MAX_CYCLES   = 2500
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  input  logic [N_CORES-1:0] hlt,
  output logic [N_CORES-1:0] core_res,
  output logic [N_CORES-1:0] core_en,
  output logic [N_CORES-1:0] halted,
  output logic [CNT_W-1:0]   cycles,
  output logic               run,
  output logic               done,
  output logic               timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_e;

  localparam int              RC_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);
  localparam bit              WDOG_EN = (MAX_CYCLES != 0);

  state_e               state_q;
  logic [RC_W-1:0]      rst_cnt_q;
  logic [N_CORES-1:0]   halted_q;
  logic [N_CORES-1:0]   halted_d;
  logic [CNT_W-1:0]     cycles_q;
  logic [CNT_W-1:0]     cycles_d;
  logic                 timeout_q;
  logic                 step_q;
  logic [N_CORES-1:0]   core_res_q;
  logic                 run_q;
  logic                 done_q;
  logic                 step_edge;
  logic [N_CORES-1:0]   core_en_c;
  logic                 en_any;

  assign step_edge = step & ~step_q;

  // Clock enables: all cores clock their reset in RESET; in RUN each live core
  // is enabled every cycle (free-run) or only on a fresh step edge.
  always_comb begin
    core_en_c = '0;
    case (state_q)
      S_RESET: core_en_c = '1;
      S_RUN:   core_en_c = ~halted_q & {N_CORES{step_mode ? step_edge : 1'b1}};
      default: core_en_c = '0;
    endcase
  end

  // Next halted flags and saturating enabled-cycle count for the RUN state.
  always_comb begin
    en_any   = |core_en_c;
    halted_d = halted_q | hlt;
    cycles_d = cycles_q;
    if (en_any && !(&cycles_q)) begin
      cycles_d = cycles_q + 1'b1;
    end
  end

  // Run sequencer: IDLE -> RESET -> RUN -> DONE, with registered status outputs.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= S_IDLE;
      rst_cnt_q  <= '0;
      halted_q   <= '0;
      cycles_q   <= '0;
      timeout_q  <= 1'b0;
      step_q     <= 1'b0;
      core_res_q <= '1;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      step_q <= step;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_RESET;
            rst_cnt_q  <= '0;
            halted_q   <= '0;
            cycles_q   <= '0;
            timeout_q  <= 1'b0;
            core_res_q <= '1;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
          end
        end
        S_RESET: begin
          if (rst_cnt_q == RC_LAST) begin
            state_q    <= S_RUN;
            core_res_q <= '0;
            run_q      <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          halted_q <= halted_d;
          cycles_q <= cycles_d;
          // A final halt on the same edge as the watchdog limit wins.
          if (&halted_d) begin
            state_q   <= S_DONE;
            run_q     <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b0;
          end else if (WDOG_EN && en_any && (cycles_d == MAX_CNT)) begin
            state_q   <= S_DONE;
            run_q     <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_res = core_res_q;
  assign core_en  = core_en_c;
  assign halted   = halted_q;
  assign cycles   = cycles_q;
  assign run      = run_q;
  assign done     = done_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_goofy_run_ctrl.sv
// Testbench for goofy_run_ctrl: two instances (3 cores with a 20-cycle
// watchdog; 1 core, 4-bit counter, watchdog off) share control stimulus.
// A driver advances a behavioural model per cycle and queues the expected
// outputs; a monitor pops and compares them against both instances.
module tb_goofy_run_ctrl;

  logic       clk;
  logic       res_n;
  logic       start;
  logic       step_mode;
  logic       step;
  logic [2:0] hlt_a;
  logic [0:0] hlt_b;

  logic [2:0]  core_res_a, core_en_a, halted_a;
  logic [15:0] cycles_a;
  logic        run_a, done_a, timeout_a;
  logic [0:0]  core_res_b, core_en_b, halted_b;
  logic [3:0]  cycles_b;
  logic        run_b, done_b, timeout_b;

  int checks;
  int failures;

  goofy_run_ctrl #(.N_CORES(3), .RESET_CYCLES(2), .CNT_W(16), .MAX_CYCLES(20)) dut_a (
    .clk(clk), .res_n(res_n), .start(start), .step_mode(step_mode), .step(step),
    .hlt(hlt_a), .core_res(core_res_a), .core_en(core_en_a), .halted(halted_a),
    .cycles(cycles_a), .run(run_a), .done(done_a), .timeout(timeout_a)
  );

  goofy_run_ctrl #(.N_CORES(1), .RESET_CYCLES(1), .CNT_W(4), .MAX_CYCLES(0)) dut_b (
    .clk(clk), .res_n(res_n), .start(start), .step_mode(step_mode), .step(step),
    .hlt(hlt_b), .core_res(core_res_b), .core_en(core_en_b), .halted(halted_b),
    .cycles(cycles_b), .run(run_b), .done(done_b), .timeout(timeout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: rleft = reset cycles still to go (in reset phase).
  typedef struct {
    int         rleft;
    bit         running;
    bit         fin;
    logic [7:0] halted;
    int         cycles;
    bit         to;
    bit         step_q;
  } mst_t;

  typedef struct {
    logic [7:0] res;
    logic [7:0] en;
    logic [7:0] halted;
    int         cycles;
    bit         run;
    bit         done;
    bit         to;
  } obs_t;

  typedef struct {
    obs_t pre_a;
    obs_t post_a;
    obs_t pre_b;
    obs_t post_b;
  } item_t;

  item_t sb[$];
  mst_t  ma, mb;

  function automatic logic [7:0] mask(int n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic obs_t observe(mst_t s, int n, bit smode, bit stp);
    obs_t o;
    o = '{default: 0};
    o.res = (s.running || s.fin) ? 8'h00 : mask(n);
    if (s.rleft > 0) begin
      o.en = mask(n);
    end else if (s.running) begin
      for (int i = 0; i < n; i++)
        o.en[i] = !s.halted[i] && (!smode || (stp && !s.step_q));
    end
    o.halted = s.halted;
    o.cycles = s.cycles;
    o.run    = s.running;
    o.done   = s.fin;
    o.to     = s.to;
    return o;
  endfunction

  function automatic mst_t advance(mst_t s, int n, int rc, int maxc, int cw,
                                   bit st, bit smode, bit stp, logic [7:0] h);
    mst_t r;
    obs_t o;
    int   sat;
    r   = s;
    o   = observe(s, n, smode, stp);
    sat = (1 << cw) - 1;
    if (s.rleft > 0) begin
      r.rleft = s.rleft - 1;
      if (r.rleft == 0) r.running = 1'b1;
    end else if (s.running) begin
      r.halted = s.halted | (h & mask(n));
      if (o.en != 0) r.cycles = (s.cycles >= sat) ? sat : s.cycles + 1;
      if (r.halted == mask(n)) begin
        r.running = 1'b0; r.fin = 1'b1; r.to = 1'b0;
      end else if (maxc != 0 && o.en != 0 && r.cycles == maxc) begin
        r.running = 1'b0; r.fin = 1'b1; r.to = 1'b1;
      end
    end else if (st) begin
      r.rleft  = rc;
      r.fin    = 1'b0;
      r.halted = '0;
      r.cycles = 0;
      r.to     = 1'b0;
    end
    r.step_q = stp;
    return r;
  endfunction

  function automatic obs_t act_a();
    obs_t o;
    o.res = 8'(core_res_a); o.en = 8'(core_en_a); o.halted = 8'(halted_a);
    o.cycles = int'(cycles_a); o.run = run_a; o.done = done_a; o.to = timeout_a;
    return o;
  endfunction

  function automatic obs_t act_b();
    obs_t o;
    o.res = 8'(core_res_b); o.en = 8'(core_en_b); o.halted = 8'(halted_b);
    o.cycles = int'(cycles_b); o.run = run_b; o.done = done_b; o.to = timeout_b;
    return o;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(string tag, obs_t e, obs_t a, bit with_en);
    chk({tag, ".core_res"}, 32'(a.res), 32'(e.res));
    if (with_en) chk({tag, ".core_en"}, 32'(a.en), 32'(e.en));
    chk({tag, ".halted"}, 32'(a.halted), 32'(e.halted));
    chk({tag, ".cycles"}, 32'(a.cycles), 32'(e.cycles));
    chk({tag, ".run"}, 32'(a.run), 32'(e.run));
    chk({tag, ".done"}, 32'(a.done), 32'(e.done));
    chk({tag, ".timeout"}, 32'(a.to), 32'(e.to));
  endtask

  // One clock cycle: queue expectations for the current inputs, advance the
  // model across the coming rising edge, then wait for the next falling edge.
  task automatic tick();
    item_t it;
    if (!res_n) begin
      ma = '{default: 0};
      mb = '{default: 0};
      it.pre_a = observe(ma, 3, step_mode, step);
      it.pre_b = observe(mb, 1, step_mode, step);
    end else begin
      it.pre_a = observe(ma, 3, step_mode, step);
      it.pre_b = observe(mb, 1, step_mode, step);
      ma = advance(ma, 3, 2, 20, 16, start, step_mode, step, 8'(hlt_a));
      mb = advance(mb, 1, 1, 0, 4, start, step_mode, step, 8'(hlt_b));
    end
    it.post_a = observe(ma, 3, step_mode, step);
    it.post_b = observe(mb, 1, step_mode, step);
    sb.push_back(it);
    @(negedge clk);
  endtask

  task automatic finish_all();
    hlt_a = '1; hlt_b = '1; tick();
    hlt_a = '0; hlt_b = '0; tick();
  endtask

  // Monitor: pre-edge check (incl. combinational enables), then post-edge check.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        cmp("A.pre", it.pre_a, act_a(), 1'b1);
        cmp("B.pre", it.pre_b, act_b(), 1'b1);
        @(posedge clk);
        #1;
        cmp("A.post", it.post_a, act_a(), 1'b0);
        cmp("B.post", it.post_b, act_b(), 1'b0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL sim_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    checks = 0; failures = 0;
    res_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    hlt_a = '0; hlt_b = '0;
    ma = '{default: 0};
    mb = '{default: 0};
    @(negedge clk);
    repeat (3) tick();
    chk("rst.core_res_a", 32'(core_res_a), 32'h7);
    chk("rst.cycles_a", 32'(cycles_a), 0);
    res_n = 1'b1;
    tick();

    // Free run with no halts: A hits the watchdog, B saturates at 15.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 60 && !ma.fin; k++) tick();
    chk("wd.done_a", 32'(done_a), 1);
    chk("wd.timeout_a", 32'(timeout_a), 1);
    chk("wd.cycles_a", 32'(cycles_a), 20);
    chk("wd.run_a", 32'(run_a), 0);
    chk("sat.cycles_b", 32'(cycles_b), 15);
    chk("sat.run_b", 32'(run_b), 1);
    finish_all();

    // Staggered halts at 5, 8, 12 on A; B halts at 10.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 60 && !ma.fin; k++) begin
      hlt_a = {ma.running && ma.cycles == 11, ma.running && ma.cycles == 7,
               ma.running && ma.cycles == 4};
      hlt_b = mb.running && mb.cycles == 9;
      tick();
    end
    hlt_a = '0; hlt_b = '0;
    chk("halt3.halted_a", 32'(halted_a), 32'h7);
    chk("halt3.cycles_a", 32'(cycles_a), 12);
    chk("halt3.timeout_a", 32'(timeout_a), 0);
    chk("halt3.done_a", 32'(done_a), 1);
    chk("halt1.cycles_b", 32'(cycles_b), 10);
    chk("halt1.done_b", 32'(done_b), 1);

    // Single-step: 5-cycle held step then three pulses -> 4 enabled cycles.
    step_mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("restart.halted_a", 32'(halted_a), 0);
    chk("restart.core_res_a", 32'(core_res_a), 32'h7);
    for (int k = 0; k < 10 && !ma.running; k++) tick();
    step = 1'b1; repeat (5) tick();
    step = 1'b0; tick();
    repeat (3) begin
      step = 1'b1; tick();
      step = 1'b0; tick();
    end
    chk("step.cycles_a", 32'(cycles_a), 4);
    chk("step.cycles_b", 32'(cycles_b), 4);
    chk("step.run_a", 32'(run_a), 1);
    step_mode = 1'b0;
    finish_all();

    // Final halt on the watchdog edge: halt wins.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 60 && !ma.fin; k++) begin
      hlt_a = (ma.running && ma.cycles == 19) ? 3'b111 : 3'b000;
      hlt_b = mb.running && mb.cycles == 3;
      tick();
    end
    hlt_a = '0; hlt_b = '0;
    chk("tie.done_a", 32'(done_a), 1);
    chk("tie.timeout_a", 32'(timeout_a), 0);
    chk("tie.cycles_a", 32'(cycles_a), 20);

    // Asynchronous reset mid-run, then a clean rerun.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 40 && !(ma.running && ma.cycles == 7); k++) tick();
    chk("mid.cycles_a", 32'(cycles_a), 7);
    res_n = 1'b0;
    #1;
    chk("async.cycles_a", 32'(cycles_a), 0);
    chk("async.run_a", 32'(run_a), 0);
    chk("async.core_res_a", 32'(core_res_a), 32'h7);
    chk("async.core_en_a", 32'(core_en_a), 0);
    tick();
    res_n = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 10 && !ma.running; k++) tick();
    chk("rerun.cycles_a", 32'(cycles_a), 0);
    chk("rerun.run_a", 32'(run_a), 1);
    finish_all();

    // Randomised traffic.
    for (int n = 0; n < 2500; n++) begin
      start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) step_mode = ~step_mode;
      if ($urandom_range(0, 2) == 0) step = ~step;
      hlt_a = 3'($urandom) & {3{$urandom_range(0, 7) == 0}};
      hlt_b = ($urandom_range(0, 39) == 0);
      if (!res_n) res_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) res_n = 1'b0;
      tick();
    end
    res_n = 1'b1; start = 1'b0; hlt_a = '0; hlt_b = '0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/goofy_run_ctrl.md
# goofy_run_ctrl

Parametrised run controller for one or more GoofyCore instances, placed between the free-running system clock and the cores. It sequences core reset, drives a per-core clock enable that freezes each core once it asserts `hlt`, and supports free-run or single-step execution. It counts executed cycles and enforces a watchdog cycle limit, reporting `done` and `timeout` to the enclosing harness or board top.

## Interface
- `N_CORES`, 1, number of cores controlled (≥1)
- `RESET_CYCLES`, 2, cycles `core_res` stays high after `start` (≥1)
- `CNT_W`, 16, width of the cycle counter
- `MAX_CYCLES`, 2500, watchdog limit in enabled cycles; 0 disables the watchdog; must be < 2^CNT_W

- `clk`  in  1  system clock; all state on rising edge
- `res_n`  in  1  asynchronous active-low reset
- `start`  in  1  level; begins a run from IDLE or DONE
- `step_mode`  in  1  1 = single-step, 0 = free-run
- `step`  in  1  single-step request; rising edge only
- `hlt`  in  N_CORES  per-core halt from each core
- `core_res`  out  N_CORES  per-core reset, active-high
- `core_en`  out  N_CORES  per-core clock enable
- `halted`  out  N_CORES  sticky per-core halted flags
- `cycles`  out  CNT_W  enabled cycles executed in the current run
- `run`  out  1  high while in RUN
- `done`  out  1  high while in DONE
- `timeout`  out  1  run ended by the watchdog

## Operation
- Four states: IDLE, RESET, RUN, DONE.
- While `res_n` is low:
  - State is IDLE.
  - `core_res` is all ones; `core_en`, `halted`, `cycles`, `run`, `done` and `timeout` are all zero.
  - The step edge detector is cleared.
- IDLE:
  - `core_res` is all ones and `core_en` is zero.
  - `start`=1 → RESET. The reset counter, `halted`, `cycles` and `timeout` are cleared.
- RESET:
  - `core_res` is all ones and `core_en` is all ones, so the cores clock their reset.
  - After exactly RESET_CYCLES cycles in RESET → RUN, with `core_res` dropping to zero on the same edge.
- RUN:
  - `run`=1.
  - `core_en[i]` = `!halted[i] & (step_mode ? step_edge : 1)`, where `step_edge` = `step & !step_q`.
  - `halted[i]` is set on any edge where `hlt[i]`=1. It never clears inside a run.
  - `cycles` increments by 1 on each edge where any `core_en` bit is 1. It saturates at all ones.
  - All bits of `halted` set (including bits set on this edge) → DONE with `timeout`=0.
  - Otherwise, if `MAX_CYCLES`≠0 and `cycles` reaches `MAX_CYCLES` on this edge → DONE with `timeout`=1.
  - Halt and watchdog on the same edge: halt wins and `timeout`=0.
- DONE:
  - `done`=1, `core_en`=0, `core_res`=0. Cores keep their state for inspection.
  - `cycles`, `halted` and `timeout` are held.
  - `start`=1 → RESET, with the same clearing as from IDLE.
- `start` is ignored in RESET and RUN.
- A `step` held high yields exactly one enabled cycle.
- `step` pulses outside RUN are ignored, but `step_q` still tracks `step`.
- `step_mode` may change at any time and takes effect the same cycle.

## Timing
- All outputs except `core_en` are registered.
- `core_en` is combinational from state, `halted`, `step_mode`, `step` and `step_q`. It drives enable pins only, never a clock.
- `start` sampled at edge k → `core_res`/`core_en` high from edge k. `run` rises at edge k+RESET_CYCLES.
- `hlt[i]` high at edge k: the core still receives edge k. `halted[i]` and `core_en[i]`=0 take effect from edge k+1.
- Final halt at edge k → `done`=1 after edge k.
- An asynchronous `res_n` assertion mid-run forces all outputs to their reset values immediately.
- `res_n` deassertion is assumed synchronised externally.

## Test plan
- Reset, then `start` pulse, `RESET_CYCLES`=2, one core, `hlt` asserted 10 enabled cycles after `run` rises:
  - `core_res` high for 2 cycles.
  - `done`=1, `timeout`=0, `cycles`=10.
  - `core_en`=0 afterwards.
- `MAX_CYCLES`=20, `hlt` never asserted → `done`=1, `timeout`=1, `cycles`=20, `run`=0.
- `N_CORES`=3, halts at cycles 5, 8 and 12:
  - `core_en[0]` drops after 5 enabled cycles and `core_en[1]` after 8.
  - DONE is entered after 12.
  - `halted`=3'b111 and `cycles`=12.
- `step_mode`=1, `step` held high for 5 cycles, then 3 single-cycle pulses → `cycles`=4, each pulse gives exactly one `core_en` cycle.
- `MAX_CYCLES`=6 with `hlt` asserted on the 6th enabled cycle → `done`=1, `timeout`=0.
- `res_n` dropped mid-RUN with `cycles`=7 → all outputs return to reset values at once. A following `start` reruns from `cycles`=0. `start` in DONE also restarts with cleared `halted`.
